bitwise_op_responder: RTL and testbench
=======================================

// Module: bitwise_op_responder
// PURPOSE
//  Request/response engine that executes bitwise operations on operand pairs.
//  Sits behind any stimulus or initiator that drives operand/opcode requests.
//  Accepts one request per valid/ready handshake and returns one tagged result.
//  Logic ops take 1 cycle; POPCNT is computed serially, 1 bit per cycle.
// PARAMETERS
//  W       8  operand/result width (>=2)
//  TAG_W   4  request tag width, echoed unchanged on the response
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      engine can accept request this cycle
//  req_op     in   3      opcode (see BEHAVIOUR)
//  req_a      in   W      operand A
//  req_b      in   W      operand B (ignored by NOT/POPCNT)
//  req_tag    in   TAG_W  request tag
//  rsp_valid  out  1      result present
//  rsp_ready  in   1      consumer takes result
//  rsp_data   out  W      result
//  rsp_tag    out  TAG_W  tag of the request that produced rsp_data
//  rsp_err    out  1      reserved-opcode flag (only with BITWISE_RSP_ERR_EN)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0 while rst_n low; rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0.
//  Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 POPCNT A.
//  FSM: IDLE -> HOLD (logic op accepted) | CALC (POPCNT accepted);
//       CALC -> HOLD after W bit-steps; HOLD -> IDLE on rsp_ready with no new accept.
//  req_ready = (IDLE) | (HOLD & rsp_ready); never high in CALC.
//  Accept = req_valid & req_ready on a rising edge (edge N).
//  Logic op: rsp_valid=1 and rsp_data/rsp_tag valid after edge N (1-cycle latency).
//  POPCNT: shift reg loaded with A at edge N; edges N+1..N+W add LSB to count and shift right.
//    rsp_valid rises after edge N+W; count is zero-extended to W bits.
//  Response is held stable (data, tag, err) while rsp_valid & !rsp_ready.
//  HOLD & rsp_ready & req_valid: old response retires and new request accepts on the same edge.
//    Logic op: rsp_valid stays 1 with new data (back-to-back, 1 result/cycle).
//    POPCNT: rsp_valid drops to 0 while the engine goes to CALC.
//  rsp_ready while rsp_valid=0 has no effect.
//  rst_n low mid-CALC or mid-HOLD: the in-flight result is discarded, and all outputs go to their reset values immediately.
//  Request inputs are don't-care when req_valid=0 and are sampled only at accept.
// CONFIGURATION
//  `BITWISE_RSP_ERR_EN defined:
//    Opcode 7 is reserved instead of POPCNT and follows the 1-cycle logic-op path.
//    It returns rsp_data=0 and rsp_err=1.
//    rsp_err=0 for all other opcodes.
//  Not defined:
//    Opcode 7 is POPCNT.
//    rsp_err is tied to 0.
//    CALC is still built.
// STRUCTURE
//  Package bitwise_ops_pkg: opcode localparams OP_AND..OP_POPCNT, FSM state encodings
//  (IDLE/CALC/HOLD), and the popcount-width function clog2(W+1).
//  Sub-module bitwise_popcnt_serial holds the shift reg, bit counter, accumulator and done pulse.
//  The top level holds the FSM, the logic-op datapath and the response register.
// TESTING
//  1. Reset, W=8:
//     - With rst_n=0, check rsp_valid=0, rsp_data=0 and req_ready=0.
//     - Release rst_n; check req_ready=1 next cycle.
//  2. Single XOR, A=8'hA5, B=8'h0F, tag=3:
//     - Check rsp_valid=1 one cycle after accept, rsp_data=8'hAA, rsp_tag=3.
//  3. POPCNT A=8'hB7, tag=9:
//     - Check req_ready=0 for 8 cycles, then rsp_data=8'd6 and rsp_tag=9.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles after a NAND (A=8'hF0, B=8'hCC).
//     - Check rsp_data=8'h3F stays stable throughout.
//     - Check req_ready=0 until rsp_ready=1.
//  5. Back-to-back with rsp_ready=1: stream AND/OR/NOT with tags 1,2,3.
//     - Check three responses on three consecutive cycles, in order, with correct tags.
//  6. Reset mid-op: pull rst_n low 3 cycles into a POPCNT.
//     - Check rsp_valid stays 0 with no stale response.
//     - With BITWISE_RSP_ERR_EN, check op 7 gives rsp_err=1 and rsp_data=0.

Source files
------------

// File: rtl/bitwise_ops_pkg.sv
// Shared opcodes, FSM state encoding and popcount width helper for the bitwise responder.
package bitwise_ops_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_NOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_NOT    = 3'd6;
    localparam logic [2:0] OP_POPCNT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int popcnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bitwise_popcnt_serial.sv
// Serial population count: one operand bit per cycle over W cycles after start.
module bitwise_popcnt_serial
    import bitwise_ops_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = popcnt_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    output logic          done,
    output logic [CW-1:0] count
);

    logic [W-1:0]  shreg;
    logic [CW-1:0] steps;
    logic [CW-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            steps <= '0;
            acc   <= '0;
        end else if (start) begin
            shreg <= a;
            steps <= CW'(W);
            acc   <= '0;
        end else if (steps != '0) begin
            acc   <= acc + CW'(shreg[0]);
            shreg <= shreg >> 1;
            steps <= steps - CW'(1);
        end
    end

    // done and count describe the final step so the caller can register the result on that edge
    assign done  = (steps == CW'(1));
    assign count = acc + CW'(shreg[0]);

endmodule

// File: rtl/bitwise_op_responder.sv
// Valid/ready request engine for bitwise ops with tagged responses.
// Optional macro BITWISE_RSP_ERR_EN turns opcode 7 into a reserved op flagged on rsp_err.
//
// state | meaning
// IDLE  | no response pending, ready for a request
// CALC  | serial popcount in progress, no requests accepted
// HOLD  | response presented, waiting for rsp_ready
module bitwise_op_responder
    import bitwise_ops_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int CW = popcnt_width(W);

    state_t        state, state_nxt;
    logic          run;
    logic          accept;
    logic          is_pop;
    logic [W-1:0]  logic_res;
    logic          pop_done;
    logic [CW-1:0] pop_count;

`ifdef BITWISE_RSP_ERR_EN
    logic is_rsv;
    logic err_q;
    assign is_pop  = 1'b0;
    assign is_rsv  = (req_op == OP_POPCNT);
    assign rsp_err = err_q;
`else
    assign is_pop  = (req_op == OP_POPCNT);
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        logic_res = '0;
        case (req_op)
            OP_AND:  logic_res = req_a & req_b;
            OP_OR:   logic_res = req_a | req_b;
            OP_XOR:  logic_res = req_a ^ req_b;
            OP_NAND: logic_res = ~(req_a & req_b);
            OP_NOR:  logic_res = ~(req_a | req_b);
            OP_XNOR: logic_res = ~(req_a ^ req_b);
            OP_NOT:  logic_res = ~req_a;
            default: logic_res = '0;
        endcase
    end

    // run keeps req_ready low through reset and for the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            ST_IDLE: req_ready = run;
            ST_HOLD: req_ready = rsp_ready;
            default: req_ready = 1'b0;
        endcase
        accept = req_valid & req_ready;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_pop ? ST_CALC : ST_HOLD;
            ST_CALC: if (pop_done) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (rsp_ready) begin
                    if (accept) state_nxt = is_pop ? ST_CALC : ST_HOLD;
                    else        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    bitwise_popcnt_serial #(.W(W), .CW(CW)) u_popcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept & is_pop),
        .a     (req_a),
        .done  (pop_done),
        .count (pop_count)
    );

    // popcount tag is captured at accept and sits in rsp_tag while rsp_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (accept) begin
            rsp_valid <= !is_pop;
            rsp_data  <= is_pop ? '0 : logic_res;
            rsp_tag   <= req_tag;
        end else if (state == ST_CALC && pop_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= W'(pop_count);
        end else if (state == ST_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef BITWISE_RSP_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= is_rsv;
    end
`endif

endmodule

// File: tb/tb_bitwise_op_responder.sv
// Scoreboard bench for bitwise_op_responder; honours BITWISE_RSP_ERR_EN when defined.
module tb_bitwise_op_responder;

    localparam int W     = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    typedef struct packed {
        logic [W-1:0]     d;
        logic [TAG_W-1:0] t;
        logic             e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bitwise_op_responder #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t r;
        r.t = tag;
        r.e = 1'b0;
        r.d = '0;
        case (op)
            3'd0: r.d = a & b;
            3'd1: r.d = a | b;
            3'd2: r.d = a ^ b;
            3'd3: r.d = ~(a & b);
            3'd4: r.d = ~(a | b);
            3'd5: r.d = ~(a ^ b);
            3'd6: r.d = ~a;
            default: begin
`ifdef BITWISE_RSP_ERR_EN
                r.d = '0;
                r.e = 1'b1;
`else
                for (int i = 0; i < W; i++) r.d = r.d + W'(a[i]);
`endif
            end
        endcase
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_tag !== '0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b data=%h tag=%h err=%b required 0/00/0/0",
                     rsp_valid, rsp_data, rsp_tag, rsp_err);
        end
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: req_ready=%b required 0", req_ready);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_xor();
        exp_t e;
        rsp_ready = 1'b1;
        drive(3'd2, 8'hA5, 8'h0F, 4'd3);
        exp_q.push_back(model(3'd2, 8'hA5, 8'h0F, 4'd3));
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL xor_valid: rsp_valid=%b required 1", rsp_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data !== e.d || rsp_tag !== e.t || rsp_err !== e.e) begin
            n_bad++;
            $display("FAIL xor_rsp: data=%h tag=%h err=%b required %h/%h/%b",
                     rsp_data, rsp_tag, rsp_err, e.d, e.t, e.e);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL xor_retire: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    // logic op in HOLD followed directly by opcode 7
    task automatic test_op7();
        exp_t e;
        rsp_ready = 1'b1;
        drive(3'd1, 8'h0F, 8'h30, 4'd2);
        exp_q.push_back(model(3'd1, 8'h0F, 8'h30, 4'd2));
        step();
        drive(3'd7, 8'hB7, 8'h00, 4'd9);
        n_cmp++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL op7_pre_hold: valid=%b ready=%b required 1/1", rsp_valid, req_ready);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data !== e.d || rsp_tag !== e.t) begin
            n_bad++;
            $display("FAIL op7_pre_rsp: data=%h tag=%h required %h/%h", rsp_data, rsp_tag, e.d, e.t);
        end
        exp_q.push_back(model(3'd7, 8'hB7, 8'h00, 4'd9));
        step();
        req_valid = 1'b0;
`ifndef BITWISE_RSP_ERR_EN
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL popcnt_busy[%0d]: ready=%b valid=%b required 0/0", i, req_ready, rsp_valid);
            end
            step();
        end
`endif
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL op7_valid: rsp_valid=%b required 1", rsp_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data !== e.d || rsp_tag !== e.t || rsp_err !== e.e) begin
            n_bad++;
            $display("FAIL op7_rsp: data=%h tag=%h err=%b required %h/%h/%b",
                     rsp_data, rsp_tag, rsp_err, e.d, e.t, e.e);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL op7_retire: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        rsp_ready = 1'b0;
        drive(3'd3, 8'hF0, 8'hCC, 4'd5);
        exp_q.push_back(model(3'd3, 8'hF0, 8'hCC, 4'd5));
        step();
        drive(3'd2, 8'h11, 8'h22, 4'd6);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.d || rsp_tag !== e.t) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h tag=%h required 1/%h/%h",
                         i, rsp_valid, rsp_data, rsp_tag, e.d, e.t);
            end
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_ready[%0d]: req_ready=%b required 0", i, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release_ready: req_ready=%b required 1", req_ready);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data !== e.d || rsp_tag !== e.t) begin
            n_bad++;
            $display("FAIL bp_nand: data=%h tag=%h required %h/%h", rsp_data, rsp_tag, e.d, e.t);
        end
        exp_q.push_back(model(3'd2, 8'h11, 8'h22, 4'd6));
        step();
        req_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.d || rsp_tag !== e.t) begin
            n_bad++;
            $display("FAIL bp_next: valid=%b data=%h tag=%h required 1/%h/%h",
                     rsp_valid, rsp_data, rsp_tag, e.d, e.t);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops [6];
        logic [W-1:0] as  [6];
        logic [W-1:0] bs  [6];
        exp_t e;
        ops = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd5, 3'd2};
        as  = '{8'h3C, 8'h81, 8'h5A, 8'h12, 8'h99, 8'hFF};
        bs  = '{8'hF5, 8'h18, 8'h00, 8'h40, 8'h0F, 8'h7E};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as[i], bs[i], TAG_W'(i + 1));
            exp_q.push_back(model(ops[i], as[i], bs[i], TAG_W'(i + 1)));
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_ready[%0d]: req_ready=%b required 1", i, req_ready);
            end
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.d || rsp_tag !== e.t) begin
                n_bad++;
                $display("FAIL b2b_rsp[%0d]: valid=%b data=%h tag=%h required 1/%h/%h",
                         i, rsp_valid, rsp_data, rsp_tag, e.d, e.t);
            end
        end
        req_valid = 1'b0;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rsp_ready = 1'b0;
        drive(3'd7, 8'hFF, 8'h00, 4'd7);
        step();
        req_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_tag !== '0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs: valid=%b data=%h tag=%h err=%b ready=%b required all 0",
                     rsp_valid, rsp_data, rsp_tag, rsp_err, req_ready);
        end
        repeat (2) step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_stale[%0d]: rsp_valid=%b required 0", i, rsp_valid);
            end
        end
        drive(3'd2, 8'h3C, 8'hFF, 4'hE);
        exp_q.push_back(model(3'd2, 8'h3C, 8'hFF, 4'hE));
        step();
        req_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.d || rsp_tag !== e.t) begin
            n_bad++;
            $display("FAIL midreset_recover: valid=%b data=%h tag=%h required 1/%h/%h",
                     rsp_valid, rsp_data, rsp_tag, e.d, e.t);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_xor();
        test_op7();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
